// File: rtl/br_mask_ctrl_if.sv
// br_mask_ctrl_if: dispatch/resolve inputs and mask/recovery outputs of the branch mask controller
interface br_mask_ctrl_if #(parameter int BR_NUM = 4);
  localparam int CW = $clog2(BR_NUM) + 1;
  logic              br_dispatch_i;
  logic              br_resolve_vld_i;
  logic [BR_NUM-1:0] br_resolve_mask_i;
  logic              br_mispredict_i;
  logic [BR_NUM-1:0] br_mask_o;
  logic [BR_NUM-1:0] ent_mask_bit_o;
  logic [BR_NUM-1:0] alloc_mask_o;
  logic              full_o;
  logic [CW-1:0]     br_cnt_o;
  logic              rc_vld_o;
  logic [BR_NUM-1:0] rc_sel_o;
  logic [BR_NUM-1:0] squash_mask_o;
  modport master (
    output br_dispatch_i, br_resolve_vld_i, br_resolve_mask_i, br_mispredict_i,
    input  br_mask_o, ent_mask_bit_o, alloc_mask_o, full_o, br_cnt_o, rc_vld_o, rc_sel_o, squash_mask_o
  );
  modport slave (
    input  br_dispatch_i, br_resolve_vld_i, br_resolve_mask_i, br_mispredict_i,
    output br_mask_o, ent_mask_bit_o, alloc_mask_o, full_o, br_cnt_o, rc_vld_o, rc_sel_o, squash_mask_o
  );
endinterface

// File: rtl/br_mask_ctrl.sv
// br_mask_ctrl: branch tag allocation, resolve bookkeeping and mispredict recovery selection
module br_mask_ctrl #(
  parameter int BR_NUM = 4
) (
  input logic          clk,
  input logic          rst_n,
  br_mask_ctrl_if.slave bus
);
  localparam int CW = $clog2(BR_NUM) + 1;
  localparam logic [BR_NUM-1:0] ONE = {{(BR_NUM-1){1'b0}}, 1'b1};
  logic [BR_NUM-1:0] r_mask;
  logic [BR_NUM-1:0] r_dep [BR_NUM];
  logic              w_res_ok;
  logic              w_mis;
  logic              w_full;
  logic [BR_NUM-1:0] w_clr;
  logic [BR_NUM-1:0] w_alloc;
  logic [BR_NUM-1:0] w_dep_sel;
  logic [CW-1:0]     w_cnt;
  // only a one-hot tag naming a live entry is acted on; reset masks everything combinationally
  assign w_res_ok = rst_n && bus.br_resolve_vld_i && $onehot(bus.br_resolve_mask_i)
                    && |(r_mask & bus.br_resolve_mask_i);
  assign w_mis    = w_res_ok && bus.br_mispredict_i;
  assign w_clr    = (w_res_ok && !bus.br_mispredict_i) ? bus.br_resolve_mask_i : '0;
  assign w_full   = &r_mask;
  assign w_alloc  = (rst_n && bus.br_dispatch_i && !w_full && !w_mis) ? (~r_mask & (r_mask + ONE)) : '0;
  always_comb begin
    w_dep_sel = '0;
    w_cnt     = '0;
    for (int i = 0; i < BR_NUM; i++) begin
      w_dep_sel = w_dep_sel | (bus.br_resolve_mask_i[i] ? r_dep[i] : '0);
      w_cnt     = w_cnt + CW'(r_mask[i]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
      for (int i = 0; i < BR_NUM; i++) r_dep[i] <= '0;
    end else if (w_mis) begin
      r_mask <= w_dep_sel;
    end else begin
      r_mask <= (r_mask & ~w_clr) | w_alloc;
      for (int i = 0; i < BR_NUM; i++) r_dep[i] <= w_alloc[i] ? (r_mask & ~w_clr) : (r_dep[i] & ~w_clr);
    end
  end
  assign bus.br_mask_o      = r_mask;
  assign bus.ent_mask_bit_o = r_mask;
  assign bus.alloc_mask_o   = w_alloc;
  assign bus.full_o         = w_full;
  assign bus.br_cnt_o       = w_cnt;
  assign bus.rc_vld_o       = w_mis;
  assign bus.rc_sel_o       = w_mis ? bus.br_resolve_mask_i : '0;
  assign bus.squash_mask_o  = w_mis ? (r_mask & ~w_dep_sel) : '0;
endmodule
